negator: RTL and testbench



---
 rtl/negator_pkg.sv | 12 +
 rtl/negate_core.sv | 33 +++
 rtl/negator.sv | 49 ++++
 tb/tb_negator.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/negator_pkg.sv
// Shared constants and helpers for the conditional negation unit.
package negator_pkg;

  localparam int NEG_WIDTH_DEFAULT = 8;

  // Most-negative two's-complement value for a given width: a 1 followed by
  // width-1 zeros, returned in a 64-bit container for the caller to slice.
  function automatic logic [63:0] most_negative(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/negate_core.sv
// Combinational core: conditional two's-complement negation with status flags.
module negate_core
  import negator_pkg::*;
#(
  parameter int WIDTH = NEG_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] number,
  input  logic             enable,
  output logic [WIDTH-1:0] neg,
  output logic             ovf,
  output logic             zro
);

  localparam logic [63:0]      MOST_NEG_64 = most_negative(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG    = MOST_NEG_64[WIDTH-1:0];

  logic signed [WIDTH-1:0] number_s;
  logic signed [WIDTH-1:0] negated_s;

  assign number_s = number;

  // Negate modulo 2^WIDTH (most-negative wraps to itself) or pass through.
  always_comb begin
    negated_s = -number_s;
    neg       = number;
    if (enable) begin
      neg = negated_s;
    end
    ovf = enable && (number == MOST_NEG);
    zro = (neg == '0);
  end

endmodule

// File: rtl/negator.sv
// Registered conditional negator: one-cycle latency, valid strobe, zero and
// overflow flags. Every flop is cleared by the asynchronous reset so no X
// leaks out of the held registers.
module negator
  import negator_pkg::*;
#(
  parameter int WIDTH = NEG_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] number,
  input  logic             enable,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] neg_p0;
  logic             ovf_p0;
  logic             zro_p0;

  negate_core #(.WIDTH(WIDTH)) u_core (
    .number (number),
    .enable (enable),
    .neg    (neg_p0),
    .ovf    (ovf_p0),
    .zro    (zro_p0)
  );

  // Stage p0 -> output: capture result and flags on valid input, else hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= neg_p0;
        zero     <= zro_p0;
        overflow <= ovf_p0;
      end
    end
  end

endmodule

// File: tb/tb_negator.sv
// Scoreboard bench for negator: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_negator;

  logic       clock;
  logic       reset;
  logic [7:0] number;
  logic       enable;
  logic       in_valid;
  logic [7:0] result;
  logic       out_valid;
  logic       zero;
  logic       overflow;

  typedef struct {
    logic [7:0] r;
    logic       z;
    logic       o;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  negator #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .number    (number),
    .enable    (enable),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one valid operand and record what should emerge one edge later.
  task automatic issue(input logic [7:0] n, input logic en,
                       input logic [7:0] r, input logic z, input logic o);
    exp_t e;
    number   = n;
    enable   = en;
    in_valid = 1'b1;
    e.r = r;
    e.z = z;
    e.o = o;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: compare every presented output against the head of the queue.
  always @(negedge clock) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: result 0x%02h with no pending expectation at %0t",
                 result, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.r);
        chk("zero", {7'd0, zero}, {7'd0, e.z});
        chk("overflow", {7'd0, overflow}, {7'd0, e.o});
      end
    end
  end

  initial begin
    reset    = 1'b0;
    number   = 8'h00;
    enable   = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("reset_result", result, 8'h00);
    chk("reset_out_valid", {7'd0, out_valid}, 8'h00);
    chk("reset_zero", {7'd0, zero}, 8'h00);
    chk("reset_overflow", {7'd0, overflow}, 8'h00);
    @(posedge clock);
    #1 reset = 1'b0;

    // Back-to-back directed vectors.
    issue(8'h36, 1'b0, 8'h36, 1'b0, 1'b0);
    issue(8'h36, 1'b0, 8'h36, 1'b0, 1'b0);
    issue(8'h36, 1'b1, 8'hCA, 1'b0, 1'b0);
    issue(8'hB3, 1'b1, 8'h4D, 1'b0, 1'b0);
    issue(8'hFF, 1'b1, 8'h01, 1'b0, 1'b0);
    issue(8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    issue(8'h80, 1'b1, 8'h80, 1'b0, 1'b1);
    issue(8'h80, 1'b0, 8'h80, 1'b0, 1'b0);
    issue(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    issue(8'h36, 1'b1, 8'hCA, 1'b0, 1'b0);

    // Hold: no valid input, result stays, out_valid drops.
    idle(1);
    chk("hold_result", result, 8'hCA);
    chk("hold_out_valid", {7'd0, out_valid}, 8'h00);
    chk("hold_zero", {7'd0, zero}, 8'h00);

    // Mid-cycle asynchronous reset.
    #2 reset = 1'b1;
    #1;
    chk("midreset_result", result, 8'h00);
    chk("midreset_out_valid", {7'd0, out_valid}, 8'h00);
    chk("midreset_zero", {7'd0, zero}, 8'h00);
    chk("midreset_overflow", {7'd0, overflow}, 8'h00);
    #3 reset = 1'b0;

    // First edge after release is a normal cycle.
    issue(8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
